// File: rtl/slot_pkg.sv
// Shared definitions for the slot grid controller: controller states,
// payline counting helpers and the per-cell home symbol.
package slot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    SPIN    = 3'd2,
    EVAL    = 3'd3,
    PAY     = 3'd4,
    CASHOUT = 3'd5
  } state_t;

  // Rows, then columns, then both diagonals when the grid is square.
  function automatic int num_lines(input int rows, input int cols);
    return rows + cols + ((rows == cols) ? 2 : 0);
  endfunction

  // Width of the payline index register.
  function automatic int line_idx_w(input int rows, input int cols);
    return (num_lines(rows, cols) > 1) ? $clog2(num_lines(rows, cols)) : 1;
  endfunction

  // Even cells rest on symbol 0, odd cells rest on the top symbol.
  function automatic int home_value(input int idx, input int num_sym);
    return ((idx % 2) == 0) ? 0 : (num_sym - 1);
  endfunction

endpackage

// File: rtl/slot_reel.sv
// One grid cell: reloads its home symbol, steps once per cycle while running
// and freezes on the symbol it shows when its stop request arrives.
module slot_reel #(
  parameter int SYM_W   = 3,
  parameter int NUM_SYM = 5,
  parameter bit DIR     = 1'b0,  // 0: counts up, 1: counts down
  parameter int HOME    = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_home_i,
  input  logic             run_i,
  input  logic             stop_req_i,
  output logic [SYM_W-1:0] val_o,
  output logic             stopped_o
);

  localparam logic [SYM_W-1:0] HOME_V = SYM_W'(HOME);
  localparam logic [SYM_W-1:0] LAST_V = SYM_W'(NUM_SYM - 1);

  logic [SYM_W-1:0] val_q, val_d, step;
  logic             stopped_q, stopped_d;

  // Next symbol in this cell's direction, wrapping modulo NUM_SYM.
  always_comb begin
    if (DIR == 1'b0) begin
      step = (val_q == LAST_V) ? '0 : val_q + SYM_W'(1);
    end else begin
      step = (val_q == '0) ? LAST_V : val_q - SYM_W'(1);
    end
  end

  // Reload wins over running; a stop holds the symbol currently shown.
  always_comb begin
    val_d     = val_q;
    stopped_d = stopped_q;
    if (load_home_i) begin
      val_d     = HOME_V;
      stopped_d = 1'b0;
    end else if (run_i && !stopped_q) begin
      if (stop_req_i) begin
        stopped_d = 1'b1;
      end else begin
        val_d = step;
      end
    end
  end

  // Cell state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      val_q     <= HOME_V;
      stopped_q <= 1'b0;
    end else begin
      val_q     <= val_d;
      stopped_q <= stopped_d;
    end
  end

  assign val_o     = val_q;
  assign stopped_o = stopped_q;

endmodule

// File: rtl/slot_grid_ctrl.sv
// Slot machine controller: credit handling, bet/spin of a ROWS x COLS reel
// grid, one-line-per-cycle payout evaluation and paced serial cash-out.
module slot_grid_ctrl
  import slot_pkg::*;
#(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int NUM_SYM   = 5,
  parameter int SYM_W     = 3,
  parameter int CREDIT_W  = 8,
  parameter int MAX_BET   = 3,
  parameter int AUTO_STOP = 64
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           coin_in,
  input  logic [$clog2(MAX_BET+1)-1:0]   bet_sel,
  input  logic                           start,
  input  logic                           cashout,
  input  logic [ROWS*COLS-1:0]           stop,
  output logic [ROWS*COLS*SYM_W-1:0]     grid,
  output logic [CREDIT_W-1:0]            credit,
  output logic                           busy,
  output logic                           coin_out,
  output logic                           coin_reject,
  output logic                           bet_err,
  output logic                           win_valid,
  output logic [CREDIT_W-1:0]            win_amt
);

  localparam int NCELL     = ROWS * COLS;
  localparam int BET_W     = $clog2(MAX_BET + 1);
  localparam int NUM_LINES = num_lines(ROWS, COLS);
  localparam int LINE_W    = line_idx_w(ROWS, COLS);
  localparam int K_W       = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;
  localparam int ACC_W     = CREDIT_W + SYM_W + BET_W + 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  // Cell index of position pos along payline ln.
  function automatic int cell_of(input int ln, input int pos);
    if (ln < ROWS)              return ln * COLS + pos;
    else if (ln < ROWS + COLS)  return pos * COLS + (ln - ROWS);
    else if (ln == ROWS + COLS) return pos * COLS + pos;
    else                        return pos * COLS + (COLS - 1 - pos);
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [BET_W-1:0]    bet_q, bet_d;
  logic [CREDIT_W-1:0] win_q, win_d;
  logic [CREDIT_W-1:0] win_amt_q, win_amt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                phase_q, phase_d;
  logic                coin_reject_q, coin_reject_d;
  logic                bet_err_q, bet_err_d;

  logic                coin_ok, bet_legal, start_ok, auto_stop;
  logic                load_home, run;
  logic [ACC_W-1:0]    acc;
  logic [CREDIT_W:0]   pay_sum;

  logic [SYM_W-1:0]    cell_val [NCELL];
  logic [NCELL-1:0]    cell_stopped;
  logic [NUM_LINES-1:0] line_hit;
  logic [SYM_W-1:0]    line_sym [NUM_LINES];

  // Reels go home whenever the controller is (re)entering or sitting in IDLE,
  // and on a legal start so the first SPIN cycle shows home symbols.
  assign load_home = (state_d == IDLE) || start_ok;
  assign run       = (state_q == SPIN);

  genvar gi, gj;

  for (gi = 0; gi < NCELL; gi++) begin : g_cell
    slot_reel #(
      .SYM_W   (SYM_W),
      .NUM_SYM (NUM_SYM),
      .DIR     ((gi % 2) == 1),
      .HOME    (home_value(gi, NUM_SYM))
    ) u_reel (
      .clk         (clk),
      .clr         (clr),
      .load_home_i (load_home),
      .run_i       (run),
      .stop_req_i  (stop[gi] | auto_stop),
      .val_o       (cell_val[gi]),
      .stopped_o   (cell_stopped[gi])
    );
    assign grid[gi*SYM_W +: SYM_W] = cell_val[gi];
  end

  // Every payline is judged in parallel; EVAL just walks the results.
  for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
    localparam int LEN = (gi < ROWS) ? COLS : ROWS;
    localparam int C0  = cell_of(gi, 0);
    logic [LEN-1:0] eq;
    for (gj = 0; gj < LEN; gj++) begin : g_pos
      assign eq[gj] = (cell_val[cell_of(gi, gj)] == cell_val[C0]);
    end
    assign line_hit[gi] = &eq;
    assign line_sym[gi] = cell_val[C0];
  end

  assign bet_legal = (bet_sel != '0) && (int'(bet_sel) <= MAX_BET) &&
                     (CREDIT_W'(bet_sel) <= credit_q);

  // Controller next state, credit arithmetic and pulse generation.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    bet_d         = bet_q;
    win_d         = win_q;
    win_amt_d     = win_amt_q;
    line_d        = line_q;
    k_d           = k_q;
    phase_d       = 1'b0;
    coin_reject_d = 1'b0;
    bet_err_d     = 1'b0;
    start_ok      = 1'b0;
    auto_stop     = 1'b0;
    acc           = '0;
    pay_sum       = '0;

    coin_ok = coin_in && (state_q != CASHOUT) && (state_q != PAY) &&
              (credit_q != CREDIT_MAX);
    if (coin_in && !coin_ok) coin_reject_d = 1'b1;
    if (coin_ok) credit_d = credit_q + CREDIT_W'(1);

    case (state_q)
      IDLE: begin
        if (coin_ok) state_d = ARMED;
      end
      ARMED: begin
        // start has priority over cashout, even when the bet is refused
        if (start) begin
          if (bet_legal) begin
            start_ok = 1'b1;
            credit_d = credit_d - CREDIT_W'(bet_sel);
            bet_d    = bet_sel;
            win_d    = '0;
            k_d      = '0;
            line_d   = '0;
            state_d  = SPIN;
          end else begin
            bet_err_d = 1'b1;
          end
        end else if (cashout) begin
          state_d = CASHOUT;
        end
      end
      SPIN: begin
        auto_stop = (k_q == K_W'(AUTO_STOP - 1));
        k_d       = k_q + K_W'(1);
        if (auto_stop || (&(cell_stopped | stop))) begin
          line_d  = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        acc = ACC_W'(win_q) + ACC_W'(line_sym[line_q]) * ACC_W'(bet_q);
        if (line_hit[line_q]) begin
          win_d = (acc > ACC_W'(CREDIT_MAX)) ? CREDIT_MAX : acc[CREDIT_W-1:0];
        end
        if (line_q == LINE_W'(NUM_LINES - 1)) begin
          state_d = PAY;
        end else begin
          line_d = line_q + LINE_W'(1);
        end
      end
      PAY: begin
        pay_sum   = {1'b0, credit_q} + {1'b0, win_q};
        credit_d  = pay_sum[CREDIT_W] ? CREDIT_MAX : pay_sum[CREDIT_W-1:0];
        win_amt_d = win_q;
        state_d   = (credit_d != '0) ? ARMED : IDLE;
      end
      CASHOUT: begin
        // phase 0 is the coin_out high cycle, phase 1 the gap after it
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (!phase_q) begin
          credit_d = credit_q - CREDIT_W'(1);
          phase_d  = 1'b1;
          if (credit_q == CREDIT_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      bet_q         <= '0;
      win_q         <= '0;
      win_amt_q     <= '0;
      line_q        <= '0;
      k_q           <= '0;
      phase_q       <= 1'b0;
      coin_reject_q <= 1'b0;
      bet_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      bet_q         <= bet_d;
      win_q         <= win_d;
      win_amt_q     <= win_amt_d;
      line_q        <= line_d;
      k_q           <= k_d;
      phase_q       <= phase_d;
      coin_reject_q <= coin_reject_d;
      bet_err_q     <= bet_err_d;
    end
  end

  assign credit      = credit_q;
  assign win_amt     = win_amt_q;
  assign busy        = (state_q == SPIN) || (state_q == EVAL) ||
                       (state_q == PAY)  || (state_q == CASHOUT);
  assign win_valid   = (state_q == PAY);
  assign coin_out    = (state_q == CASHOUT) && !phase_q && (credit_q != '0);
  assign coin_reject = coin_reject_q;
  assign bet_err     = bet_err_q;

endmodule

// File: tb/tb_slot_grid_ctrl.sv
// Directed bench for slot_grid_ctrl (3x3 grid, 5 symbols, 8-bit credit).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_slot_grid_ctrl;
  import slot_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        coin_in;
  logic [1:0]  bet_sel;
  logic        start;
  logic        cashout;
  logic [8:0]  stop;
  logic [26:0] grid;
  logic [7:0]  credit;
  logic        busy, coin_out, coin_reject, bet_err, win_valid;
  logic [7:0]  win_amt;

  int checks = 0;
  int errors = 0;

  slot_grid_ctrl dut (
    .clk         (clk),
    .clr         (clr),
    .coin_in     (coin_in),
    .bet_sel     (bet_sel),
    .start       (start),
    .cashout     (cashout),
    .stop        (stop),
    .grid        (grid),
    .credit      (credit),
    .busy        (busy),
    .coin_out    (coin_out),
    .coin_reject (coin_reject),
    .bet_err     (bet_err),
    .win_valid   (win_valid),
    .win_amt     (win_amt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grid with every even cell showing ev and every odd cell showing od.
  function automatic logic [26:0] grid_alt(input logic [2:0] ev, input logic [2:0] od);
    logic [26:0] g;
    g = '0;
    for (int i = 0; i < 9; i++) g[i*3 +: 3] = ((i % 2) == 0) ? ev : od;
    return g;
  endfunction

  function automatic logic [31:0] pulses();
    return 32'({coin_out, coin_reject, bet_err, win_valid});
  endfunction

  initial begin
    logic [7:0] cash_credit [6];
    cash_credit[0] = 8'd3; cash_credit[1] = 8'd2; cash_credit[2] = 8'd2;
    cash_credit[3] = 8'd1; cash_credit[4] = 8'd1; cash_credit[5] = 8'd0;

    clr = 1'b1; coin_in = 1'b0; bet_sel = 2'd0; start = 1'b0; cashout = 1'b0; stop = '0;

    // ---- reset values
    repeat (2) tick();
    clr = 1'b0;
    tick();
    $display("txn reset");
    check("reset_grid",    32'(grid),         32'(grid_alt(3'd0, 3'd4)));
    check("reset_credit",  32'(credit),       32'd0);
    check("reset_winamt",  32'(win_amt),      32'd0);
    check("reset_busy",    32'(busy),         32'd0);
    check("reset_pulses",  pulses(),          32'd0);
    check("reset_state",   32'(dut.state_q),  32'(IDLE));

    // ---- 3 coins, bet 2, every cell stopped at k=2
    coin_in = 1'b1;
    tick();
    check("coin1_state",   32'(dut.state_q),  32'(ARMED));
    check("coin1_credit",  32'(credit),       32'd1);
    repeat (2) tick();
    coin_in = 1'b0;
    $display("txn coins x3 credit=%0d", credit);
    check("coin3_credit",  32'(credit),       32'd3);
    bet_sel = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    $display("txn start bet=2");
    check("spin_state",    32'(dut.state_q),  32'(SPIN));
    check("spin_credit",   32'(credit),       32'd1);
    check("spin_k0_grid",  32'(grid),         32'(grid_alt(3'd0, 3'd4)));
    check("spin_busy",     32'(busy),         32'd1);
    repeat (2) tick();
    check("spin_k2_grid",  32'(grid),         32'(grid_alt(3'd2, 3'd2)));
    stop = 9'h1FF;
    tick();
    stop = '0;
    $display("txn stop all at k=2");
    check("eval_state",    32'(dut.state_q),  32'(EVAL));
    check("eval_grid",     32'(grid),         32'(grid_alt(3'd2, 3'd2)));
    repeat (8) tick();
    check("pay_state",     32'(dut.state_q),  32'(PAY));
    check("pay_winvalid",  32'(win_valid),    32'd1);
    check("pay_winamt_old",32'(win_amt),      32'd0);
    tick();
    // 8 winning lines x symbol 2 x bet 2 = 32; credit 3 - 2 + 32 = 33
    $display("txn payout win=%0d credit=%0d", win_amt, credit);
    check("post_pay_state",  32'(dut.state_q), 32'(ARMED));
    check("post_pay_credit", 32'(credit),      32'd33);
    check("post_pay_winamt", 32'(win_amt),     32'd32);
    check("post_pay_wv",     32'(win_valid),   32'd0);
    check("post_pay_grid",   32'(grid),        32'(grid_alt(3'd2, 3'd2)));

    // ---- illegal bets with credit 1
    clr = 1'b1;
    tick();
    clr = 1'b0;
    coin_in = 1'b1;
    tick();
    coin_in = 1'b0;
    check("be_credit",     32'(credit),       32'd1);
    bet_sel = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    $display("txn start bet=2 credit=1");
    check("be2_pulse",     32'(bet_err),      32'd1);
    check("be2_credit",    32'(credit),       32'd1);
    check("be2_state",     32'(dut.state_q),  32'(ARMED));
    tick();
    check("be2_clear",     32'(bet_err),      32'd0);
    bet_sel = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    $display("txn start bet=0 credit=1");
    check("be0_pulse",     32'(bet_err),      32'd1);
    check("be0_credit",    32'(credit),       32'd1);
    check("be0_state",     32'(dut.state_q),  32'(ARMED));

    // ---- cash-out of 3 credits
    coin_in = 1'b1;
    repeat (2) tick();
    coin_in = 1'b0;
    check("co_credit",     32'(credit),       32'd3);
    cashout = 1'b1;
    tick();
    cashout = 1'b0;
    $display("txn cashout credit=3");
    check("co_state",      32'(dut.state_q),  32'(CASHOUT));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("co_pulse%0d", i),  32'(coin_out), 32'((i % 2) == 0));
      check($sformatf("co_credit%0d", i), 32'(credit),   32'(cash_credit[i]));
      if (i < 5) tick();
    end
    check("co_idle",       32'(dut.state_q),  32'(IDLE));
    check("co_grid_home",  32'(grid),         32'(grid_alt(3'd0, 3'd4)));

    // ---- credit saturation
    coin_in = 1'b1;
    repeat (255) tick();
    check("sat_credit",    32'(credit),       32'd255);
    check("sat_noreject",  32'(coin_reject),  32'd0);
    tick();
    coin_in = 1'b0;
    $display("txn coin at credit=255");
    check("sat_reject",    32'(coin_reject),  32'd1);
    check("sat_hold",      32'(credit),       32'd255);
    tick();
    check("sat_reject_off",32'(coin_reject),  32'd0);

    // ---- auto-stop, bet 1, no stop buttons
    bet_sel = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("as_credit",     32'(credit),       32'd254);
    repeat (63) tick();
    // k=63: even cells 63 mod 5 = 3; odd cells (4 - 63) mod 5 = 1
    $display("txn autostop k=63");
    check("as_k63_state",  32'(dut.state_q),  32'(SPIN));
    check("as_k63_grid",   32'(grid),         32'(grid_alt(3'd3, 3'd1)));
    tick();
    check("as_eval_state", 32'(dut.state_q),  32'(EVAL));
    check("as_eval_grid",  32'(grid),         32'(grid_alt(3'd3, 3'd1)));
    repeat (8) tick();
    check("as_pay_state",  32'(dut.state_q),  32'(PAY));
    tick();
    // both diagonals show 3,3,3: win 2 x 3 x 1 = 6; 254 + 6 saturates at 255
    $display("txn autostop payout win=%0d credit=%0d", win_amt, credit);
    check("as_winamt",     32'(win_amt),      32'd6);
    check("as_credit_sat", 32'(credit),       32'd255);
    check("as_armed",      32'(dut.state_q),  32'(ARMED));

    // ---- asynchronous reset in the middle of a spin
    bet_sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("mid_busy",      32'(busy),         32'd1);
    check("mid_credit",    32'(credit),       32'd252);
    clr = 1'b1;
    #1;
    $display("txn clr mid-spin");
    check("mid_rst_credit",32'(credit),       32'd0);
    check("mid_rst_grid",  32'(grid),         32'(grid_alt(3'd0, 3'd4)));
    check("mid_rst_busy",  32'(busy),         32'd0);
    check("mid_rst_winamt",32'(win_amt),      32'd0);
    check("mid_rst_pulses",pulses(),          32'd0);
    check("mid_rst_state", 32'(dut.state_q),  32'(IDLE));
    clr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
